// File: rtl/mem_ram_pkg.sv
// Shared types and constants for the synchronous dual-port RAM family.
//   mem_state_t : clear-sequencer states (CLEAR sweep, RUN normal access)
//   RDW_OLD/NEW : same-address read-during-write policy selectors
package mem_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/mem_ram_sync_dp_if.sv
// Access bus of mem_ram_sync_dp.
//   master : drives clr_rq, write port (write_rq/wr_address/write_data/wr_be)
//            and read port (read_rq/rd_address); samples ready, read_data,
//            read_valid, addr_err
//   slave  : the RAM side of the same signals
interface mem_ram_sync_dp_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              clr_rq;
  logic              ready;
  logic              write_rq;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   wr_be;
  logic              read_rq;
  logic [ADDR_W-1:0] rd_address;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              addr_err;

  modport master (
    output clr_rq, write_rq, wr_address, write_data, wr_be, read_rq, rd_address,
    input  ready, read_data, read_valid, addr_err
  );

  modport slave (
    input  clr_rq, write_rq, wr_address, write_data, wr_be, read_rq, rd_address,
    output ready, read_data, read_valid, addr_err
  );

endinterface

// File: rtl/mem_ram_clr_seq.sv
// Clear sequencer: after reset or a clear request, sweeps addresses
// 0..DEPTH-1 one per cycle, then enters RUN.
//   clk, rst   : clock, async active-low reset
//   clr_rq     : restart a sweep (honoured only in RUN)
//   ready      : registered, high in RUN
//   sweep_addr : address written this cycle while sweeping
//   sweep_we   : registered, high in CLEAR
module mem_ram_clr_seq
  import mem_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_rq,
  output logic              ready,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_t        state;
  mem_state_t        state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;

  // State, pointer and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      ready      <= 1'b0;
      sweep_we   <= 1'b1;
    end else begin
      state      <= state_nxt;
      sweep_addr <= ptr_nxt;
      ready      <= (state_nxt == RUN);
      sweep_we   <= (state_nxt == CLEAR);
    end
  end

  // Next-state and pointer logic; a clear request mid-sweep is ignored
  always_comb begin
    state_nxt = state;
    ptr_nxt   = sweep_addr;
    case (state)
      CLEAR: begin
        if (sweep_addr == LAST_ADDR) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = sweep_addr + ADDR_W'(1);
        end
      end
      RUN: begin
        if (clr_rq) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_ram_sync_dp.sv
// Simple-dual-port synchronous RAM with byte enables, selectable
// read-during-write policy and a built-in clear sweep.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of mem_ram_sync_dp_if (clear request, write port,
//              read port, ready, registered read data/valid, addr_err)
module mem_ram_sync_dp
  import mem_ram_pkg::*;
#(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 6,
  parameter int unsigned        DEPTH    = 2 ** ADDR_W,
  parameter int unsigned        RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  mem_ram_sync_dp_if.slave    bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;

  logic              wr_ok_c;
  logic              rd_ok_c;
  logic              wr_fire_c;
  logic              rd_fire_c;
  logic [ADDR_W-1:0] wr_idx_c;
  logic [ADDR_W-1:0] rd_idx_c;
  logic [DATA_W-1:0] merged_c;
  logic [DATA_W-1:0] rd_word_c;

  mem_ram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_rq     (bus.clr_rq),
    .ready      (ready),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we)
  );

  assign bus.ready = ready;

  // Range checks, gated requests and byte-enable merge
  always_comb begin
    wr_ok_c   = (32'(bus.wr_address) < DEPTH);
    rd_ok_c   = (32'(bus.rd_address) < DEPTH);
    wr_fire_c = ready && bus.write_rq;
    rd_fire_c = ready && bus.read_rq;
    // Out-of-range addresses are steered to 0 so the array is never over-indexed
    wr_idx_c  = wr_ok_c ? bus.wr_address : '0;
    rd_idx_c  = rd_ok_c ? bus.rd_address : '0;
    merged_c  = mem[wr_idx_c];
    for (int b = 0; b < int'(BE_W); b++) begin
      if (bus.wr_be[b]) merged_c[8*b +: 8] = bus.write_data[8*b +: 8];
    end
  end

  // Read word with optional new-data bypass on a same-address write
  always_comb begin
    rd_word_c = mem[rd_idx_c];
    if (RDW_MODE == RDW_NEW && wr_fire_c && wr_ok_c &&
        bus.rd_address == bus.wr_address) begin
      rd_word_c = merged_c;
    end
    if (!rd_ok_c) rd_word_c = '0;
  end

  // Storage array: sweep writes take priority (user writes are gated off then)
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VAL;
    end else if (wr_fire_c && wr_ok_c) begin
      mem[wr_idx_c] <= merged_c;
    end
  end

  // Read register and single-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
      bus.addr_err   <= 1'b0;
    end else begin
      bus.read_valid <= rd_fire_c;
      bus.addr_err   <= (wr_fire_c && !wr_ok_c) || (rd_fire_c && !rd_ok_c);
      if (rd_fire_c) bus.read_data <= rd_word_c;
    end
  end

endmodule

// File: tb/tb_mem_ram_sync_dp.sv
module tb_mem_ram_sync_dp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // A: defaults (8-bit, 64 words, old-data RDW, INIT 0)
  mem_ram_sync_dp_if #(.DATA_W(8),  .ADDR_W(6)) ifa ();
  // B: 32-bit, 48 words, new-data RDW, non-zero INIT
  mem_ram_sync_dp_if #(.DATA_W(32), .ADDR_W(6)) ifb ();

  mem_ram_sync_dp #(
    .DATA_W(8), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .INIT_VAL(8'h00)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  mem_ram_sync_dp #(
    .DATA_W(32), .ADDR_W(6), .DEPTH(48), .RDW_MODE(1), .INIT_VAL(32'hC0DE_0000)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0] model_a [64];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    ifa.clr_rq = 0; ifa.write_rq = 0; ifa.wr_address = '0; ifa.write_data = '0;
    ifa.wr_be = '0; ifa.read_rq = 0; ifa.rd_address = '0;
  endtask

  task automatic idle_b;
    ifb.clr_rq = 0; ifb.write_rq = 0; ifb.wr_address = '0; ifb.write_data = '0;
    ifb.wr_be = '0; ifb.read_rq = 0; ifb.rd_address = '0;
  endtask

  task automatic test_reset;
    int n, ra, rb;
    rst = 0; idle_a(); idle_b();
    tick(); tick();
    n_cmp++; if (ifa.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_a got=%b want=0", ifa.ready); end
    n_cmp++; if (ifa.read_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_a got=%b want=0", ifa.read_valid); end
    n_cmp++; if (ifa.read_data !== 8'h00) begin n_err++; $display("FAIL reset_data_a got=%h want=00", ifa.read_data); end
    n_cmp++; if (ifa.addr_err !== 1'b0) begin n_err++; $display("FAIL reset_err_a got=%b want=0", ifa.addr_err); end
    n_cmp++; if (ifb.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_b got=%b want=0", ifb.ready); end
    rst = 1;
    n = 0; ra = 0; rb = 0;
    while (n < 200 && (ra == 0 || rb == 0)) begin
      tick(); n++;
      if (ifa.ready === 1'b1 && ra == 0) ra = n;
      if (ifb.ready === 1'b1 && rb == 0) rb = n;
    end
    n_cmp++; if (ra != 64) begin n_err++; $display("FAIL sweep_len_a got=%0d want=64", ra); end
    n_cmp++; if (rb != 48) begin n_err++; $display("FAIL sweep_len_b got=%0d want=48", rb); end
  endtask

  task automatic test_init_reads;
    for (int i = 0; i < 64; i++) begin
      ifa.read_rq = 1; ifa.rd_address = 6'(i);
      tick();
      n_cmp++;
      if (ifa.read_valid !== 1'b1 || ifa.read_data !== 8'h00) begin
        n_err++; $display("FAIL init_read_a[%0d] got v=%b d=%h want v=1 d=00", i, ifa.read_valid, ifa.read_data);
      end
    end
    idle_a();
    tick();
    n_cmp++; if (ifa.read_valid !== 1'b0) begin n_err++; $display("FAIL init_valid_drop got=%b want=0", ifa.read_valid); end
  endtask

  task automatic test_write_read;
    ifa.write_rq = 1; ifa.wr_address = 6'd5; ifa.write_data = 8'hA5; ifa.wr_be = 1'b1;
    tick();
    idle_a(); ifa.read_rq = 1; ifa.rd_address = 6'd5;
    tick();
    n_cmp++; if (ifa.read_data !== 8'hA5 || ifa.read_valid !== 1'b1) begin
      n_err++; $display("FAIL wr_rd_5 got v=%b d=%h want v=1 d=a5", ifa.read_valid, ifa.read_data); end
    idle_a();
    tick();
    n_cmp++; if (ifa.read_valid !== 1'b0 || ifa.read_data !== 8'hA5) begin
      n_err++; $display("FAIL hold_5 got v=%b d=%h want v=0 d=a5", ifa.read_valid, ifa.read_data); end
    // wr_be=0 is a no-op
    ifa.write_rq = 1; ifa.wr_address = 6'd5; ifa.write_data = 8'hFF; ifa.wr_be = 1'b0;
    tick();
    idle_a(); ifa.read_rq = 1; ifa.rd_address = 6'd5;
    tick();
    n_cmp++; if (ifa.read_data !== 8'hA5) begin n_err++; $display("FAIL be0_noop got=%h want=a5", ifa.read_data); end
    idle_a();
  endtask

  task automatic test_rdw_old;
    ifa.write_rq = 1; ifa.wr_address = 6'd7; ifa.write_data = 8'h12; ifa.wr_be = 1'b1;
    tick();
    ifa.write_data = 8'h34; ifa.read_rq = 1; ifa.rd_address = 6'd7;
    tick();
    n_cmp++; if (ifa.read_data !== 8'h12) begin n_err++; $display("FAIL rdw_old got=%h want=12", ifa.read_data); end
    ifa.write_rq = 0;
    tick();
    n_cmp++; if (ifa.read_data !== 8'h34) begin n_err++; $display("FAIL rdw_old_after got=%h want=34", ifa.read_data); end
    // different addresses in the same cycle are independent
    ifa.write_rq = 1; ifa.wr_address = 6'd8; ifa.write_data = 8'h56; ifa.rd_address = 6'd5;
    tick();
    n_cmp++; if (ifa.read_data !== 8'hA5) begin n_err++; $display("FAIL indep_rd got=%h want=a5", ifa.read_data); end
    ifa.write_rq = 0; ifa.rd_address = 6'd8;
    tick();
    n_cmp++; if (ifa.read_data !== 8'h56) begin n_err++; $display("FAIL indep_wr got=%h want=56", ifa.read_data); end
    idle_a();
  endtask

  task automatic test_byte_enable;
    ifb.write_rq = 1; ifb.wr_address = 6'd3; ifb.write_data = 32'h1122_3344; ifb.wr_be = 4'hF;
    tick();
    ifb.write_data = 32'hAABB_CCDD; ifb.wr_be = 4'b0101;
    tick();
    idle_b(); ifb.read_rq = 1; ifb.rd_address = 6'd3;
    tick();
    n_cmp++; if (ifb.read_data !== 32'h11BB_33DD) begin n_err++; $display("FAIL byte_en got=%h want=11bb33dd", ifb.read_data); end
    idle_b();
  endtask

  task automatic test_rdw_new;
    ifb.write_rq = 1; ifb.wr_address = 6'd7; ifb.write_data = 32'h0000_0012; ifb.wr_be = 4'hF;
    tick();
    ifb.write_data = 32'h0000_0034; ifb.read_rq = 1; ifb.rd_address = 6'd7;
    tick();
    n_cmp++; if (ifb.read_data !== 32'h0000_0034) begin n_err++; $display("FAIL rdw_new got=%h want=00000034", ifb.read_data); end
    ifb.write_data = 32'hFFFF_5600; ifb.wr_be = 4'b0010;
    tick();
    n_cmp++; if (ifb.read_data !== 32'h0000_5634) begin n_err++; $display("FAIL rdw_new_merge got=%h want=00005634", ifb.read_data); end
    ifb.write_rq = 0;
    tick();
    n_cmp++; if (ifb.read_data !== 32'h0000_5634) begin n_err++; $display("FAIL rdw_new_after got=%h want=00005634", ifb.read_data); end
    idle_b();
  endtask

  task automatic test_out_of_range;
    ifb.write_rq = 1; ifb.wr_address = 6'd50; ifb.write_data = 32'hDEAD_BEEF; ifb.wr_be = 4'hF;
    tick();
    n_cmp++; if (ifb.addr_err !== 1'b1 || ifb.read_valid !== 1'b0) begin
      n_err++; $display("FAIL oor_wr got err=%b v=%b want err=1 v=0", ifb.addr_err, ifb.read_valid); end
    idle_b();
    tick();
    n_cmp++; if (ifb.addr_err !== 1'b0) begin n_err++; $display("FAIL oor_pulse got=%b want=0", ifb.addr_err); end
    ifb.read_rq = 1; ifb.rd_address = 6'd50;
    tick();
    n_cmp++; if (ifb.read_data !== 32'h0 || ifb.read_valid !== 1'b1 || ifb.addr_err !== 1'b1) begin
      n_err++; $display("FAIL oor_rd got d=%h v=%b err=%b want d=0 v=1 err=1", ifb.read_data, ifb.read_valid, ifb.addr_err); end
    ifb.rd_address = 6'd47;
    tick();
    n_cmp++; if (ifb.read_data !== 32'hC0DE_0000 || ifb.addr_err !== 1'b0) begin
      n_err++; $display("FAIL edge_rd47 got d=%h err=%b want d=c0de0000 err=0", ifb.read_data, ifb.addr_err); end
    // dropped write must not alias onto 50-48 or 50-32
    ifb.rd_address = 6'd2;
    tick();
    n_cmp++; if (ifb.read_data !== 32'hC0DE_0000) begin n_err++; $display("FAIL oor_alias2 got=%h want=c0de0000", ifb.read_data); end
    ifb.rd_address = 6'd18;
    tick();
    n_cmp++; if (ifb.read_data !== 32'hC0DE_0000) begin n_err++; $display("FAIL oor_alias18 got=%h want=c0de0000", ifb.read_data); end
    // both ports offending: one pulse
    ifb.write_rq = 1; ifb.wr_address = 6'd63; ifb.rd_address = 6'd48;
    tick();
    n_cmp++; if (ifb.addr_err !== 1'b1) begin n_err++; $display("FAIL oor_both got=%b want=1", ifb.addr_err); end
    idle_b();
    tick();
    n_cmp++; if (ifb.addr_err !== 1'b0) begin n_err++; $display("FAIL oor_both_pulse got=%b want=0", ifb.addr_err); end
  endtask

  task automatic test_clear;
    int n;
    for (int i = 0; i < 64; i++) begin
      model_a[i] = 8'($urandom);
      ifa.write_rq = 1; ifa.wr_address = 6'(i); ifa.write_data = model_a[i]; ifa.wr_be = 1'b1;
      tick();
    end
    idle_a();
    for (int i = 0; i < 64; i += 21) begin
      ifa.read_rq = 1; ifa.rd_address = 6'(i);
      tick();
      n_cmp++; if (ifa.read_data !== model_a[i]) begin
        n_err++; $display("FAIL fill_rd[%0d] got=%h want=%h", i, ifa.read_data, model_a[i]); end
    end
    // access in the clr_rq cycle is still performed
    ifa.clr_rq = 1; ifa.read_rq = 1; ifa.rd_address = 6'd9;
    ifa.write_rq = 1; ifa.wr_address = 6'd9; ifa.write_data = ~model_a[9];
    tick();
    n_cmp++; if (ifa.ready !== 1'b0 || ifa.read_valid !== 1'b1 || ifa.read_data !== model_a[9]) begin
      n_err++; $display("FAIL clr_edge got r=%b v=%b d=%h want r=0 v=1 d=%h", ifa.ready, ifa.read_valid, ifa.read_data, model_a[9]); end
    idle_a();
    n = 0;
    while (n < 200 && ifa.ready !== 1'b1) begin
      ifa.clr_rq = (n == 10); ifa.read_rq = (n == 10);
      tick(); n++;
      if (n == 11) begin
        n_cmp++; if (ifa.read_valid !== 1'b0) begin n_err++; $display("FAIL clr_rd_ignored got=%b want=0", ifa.read_valid); end
      end
    end
    idle_a();
    n_cmp++; if (n != 64) begin n_err++; $display("FAIL clr_len got=%0d want=64", n); end
    for (int i = 0; i < 64; i++) begin
      ifa.read_rq = 1; ifa.rd_address = 6'(i);
      tick();
      n_cmp++; if (ifa.read_data !== 8'h00 || ifa.read_valid !== 1'b1) begin
        n_err++; $display("FAIL clr_rd[%0d] got v=%b d=%h want v=1 d=00", i, ifa.read_valid, ifa.read_data); end
    end
    idle_a();
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    ifa.clr_rq = 1;
    tick();
    ifa.clr_rq = 0;
    repeat (20) tick();
    rst = 0;
    tick();
    n_cmp++; if (ifa.ready !== 1'b0 || ifa.read_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst got r=%b v=%b want r=0 v=0", ifa.ready, ifa.read_valid); end
    tick();
    rst = 1;
    n = 0;
    while (n < 200 && ifa.ready !== 1'b1) begin
      tick(); n++;
    end
    n_cmp++; if (n != 64) begin n_err++; $display("FAIL midrst_len got=%0d want=64", n); end
  endtask

  initial begin
    idle_a(); idle_b();
    test_reset();
    test_init_reads();
    test_write_read();
    test_rdw_old();
    test_byte_enable();
    test_rdw_new();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
